// File: rtl/cpu_mem_pkg.sv
// Types and constants shared by the memory arbiter and the datapath.
package cpu_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 64;
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned INSTR_W    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares the single RAM port between instruction fetch and data access.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_bus_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned RAM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               if_req,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic               if_gnt,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_rdata,
    input  logic               dm_req,
    input  logic               dm_we,
    input  logic [ADDR_W-1:0]  dm_addr,
    input  logic [DATA_W-1:0]  dm_wdata,
    output logic               dm_gnt,
    output logic               dm_done,
    output logic [DATA_W-1:0]  dm_rdata,
    output logic               RCS,
    output logic               RR,
    output logic               WRR,
    output logic               EN_ADDR_PC,
    output logic               EN_ADDR_ALU,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(RAM_LAT + 1);

    // Reject nonsensical configurations at elaboration time.
    if (RAM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_param
        $error("mem_bus_arbiter: RAM_LAT and STARVE_MAX must be at least 1");
    end

    arb_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               id_q, id_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
    logic [INSTR_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  dm_rdata_q, dm_rdata_d;
    logic               if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
    logic               if_valid_q, if_valid_d, dm_done_q, dm_done_d;
    logic               rcs_q, rcs_d, rr_q, rr_d, wrr_q, wrr_d;
    logic               en_pc_q, en_pc_d, en_alu_q, en_alu_d;
    logic               busy_q, busy_d;
    logic               grant_dm_c;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    logic [STV_W-1:0] starve_q, starve_d;
    logic             starve_hit_c;

    assign starve_hit_c = (starve_q >= STV_W'(STARVE_MAX));
    assign grant_dm_c   = dm_req && !(if_req && starve_hit_c);

    // Count data grants that overtook a waiting fetch; any fetch grant clears it.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (grant_dm_c && if_req) begin
                starve_d = starve_q + STV_W'(1);
            end else if (if_req && !grant_dm_c) begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign grant_dm_c = dm_req;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        we_d        = we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        dm_done_d   = 1'b0;
        rcs_d       = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (dm_req || if_req) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(RAM_LAT - 1);
                    rcs_d   = 1'b1;
                    busy_d  = 1'b1;
                    if (grant_dm_c) begin
                        id_d        = REQ_DM;
                        we_d        = dm_we;
                        ram_addr_d  = dm_addr;
                        ram_wdata_d = dm_wdata;
                        dm_gnt_d    = 1'b1;
                    end else begin
                        id_d       = REQ_IF;
                        we_d       = 1'b0;
                        ram_addr_d = if_addr;
                        if_gnt_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    // Final access cycle: capture read data and signal completion.
                    state_d = DONE;
                    if (id_q == REQ_IF) begin
                        if_rdata_d = ram_rdata[INSTR_W-1:0];
                        if_valid_d = 1'b1;
                    end else begin
                        dm_done_d = 1'b1;
                        if (!we_q) begin
                            dm_rdata_d = ram_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    rcs_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rr_d     = rcs_d && ((id_d == REQ_IF) || !we_d);
        wrr_d    = rcs_d && (id_d == REQ_DM) && we_d;
        en_pc_d  = rcs_d && (id_d == REQ_IF);
        en_alu_d = rcs_d && (id_d == REQ_DM);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            id_q        <= REQ_IF;
            we_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            dm_done_q   <= 1'b0;
            rcs_q       <= 1'b0;
            rr_q        <= 1'b0;
            wrr_q       <= 1'b0;
            en_pc_q     <= 1'b0;
            en_alu_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            we_q        <= we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_valid_q  <= if_valid_d;
            dm_done_q   <= dm_done_d;
            rcs_q       <= rcs_d;
            rr_q        <= rr_d;
            wrr_q       <= wrr_d;
            en_pc_q     <= en_pc_d;
            en_alu_q    <= en_alu_d;
            busy_q      <= busy_d;
        end
    end

    assign if_gnt      = if_gnt_q;
    assign if_valid    = if_valid_q;
    assign if_rdata    = if_rdata_q;
    assign dm_gnt      = dm_gnt_q;
    assign dm_done     = dm_done_q;
    assign dm_rdata    = dm_rdata_q;
    assign RCS         = rcs_q;
    assign RR          = rr_q;
    assign WRR         = wrr_q;
    assign EN_ADDR_PC  = en_pc_q;
    assign EN_ADDR_ALU = en_alu_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign busy        = busy_q;

endmodule
